multi_timer: RTL and testbench

Multi-channel programmable timer: a successor to the single-channel `cnt`/`clkdiv` pair that generalises it in channel count, width and mode. It provides a shared prescaler plus `CHANNELS` independent counters. Each counter has run-time selectable direction, periodic or one-shot mode, a synchronous reload, and a sticky, software-clearable interrupt flag. It sits between the system clock domain and the interrupt/controller logic, serving as the general timebase for peripherals.

---
 rtl/multi_timer.sv | 73 +++++++
 tb/tb_multi_timer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/multi_timer.sv
// multi_timer: shared prescaler driving CHANNELS independent up/down counters
// with periodic/one-shot modes, synchronous reload and sticky interrupt flags.
module multi_timer #(
    parameter int WIDTH     = 16,
    parameter int CHANNELS  = 4,
    parameter int PRE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [PRE_WIDTH-1:0]      prescale,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       dir,
    input  logic [CHANNELS-1:0]       oneshot,
    input  logic [CHANNELS*WIDTH-1:0] top,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS-1:0]       irq_clr,
    output logic [CHANNELS*WIDTH-1:0] cnt,
    output logic [CHANNELS-1:0]       running,
    output logic [CHANNELS-1:0]       irq_pend,
    output logic                      irq
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    logic [PRE_WIDTH-1:0] pre;
    logic                 tick;

    // >= rather than == so a lowered prescale never waits for a wrap
    assign tick = pre >= prescale;

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) pre <= '0;
        else       pre <= tick ? '0 : pre + 1'b1;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t           state, state_nx;
        logic [WIDTH-1:0] c, c_nx, tp, start;
        logic             term, hit, pend, pend_nx;

        assign tp    = top[i*WIDTH +: WIDTH];
        assign start = dir[i] ? '0 : tp;
        assign term  = dir[i] ? (c >= tp) : (c == '0);
        assign hit   = !load[i] && state == RUN && en[i] && tick && term;

        always_ff @(posedge clk or negedge rstn)
            if (!rstn) begin
                state <= IDLE;
                c     <= '0;
                pend  <= 1'b0;
            end else begin
                state <= state_nx;
                c     <= c_nx;
                pend  <= pend_nx;
            end

        always_comb
            state_nx = (load[i] || state == IDLE) ? (en[i] ? RUN : IDLE) :
                       state == RUN ? (!en[i] ? IDLE : (hit && oneshot[i]) ? DONE : RUN) :
                       DONE;

        always_comb begin
            c_nx       = load[i] ? start :
                         (state == RUN && en[i] && tick) ? (term ? start : dir[i] ? c + 1'b1 : c - 1'b1) :
                         c;
            pend_nx    = hit | (pend & ~irq_clr[i]);
            running[i] = state == RUN;
        end

        assign cnt[i*WIDTH +: WIDTH] = c;
        assign irq_pend[i]           = pend;
    end

    assign irq = |irq_pend;
endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer: directed vector table on channel 0 plus hand-written
// multi-channel and asynchronous-reset sequences for multi_timer.
module tb_multi_timer;
    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [7:0]  prescale = '0;
    logic [3:0]  en = '0, dir = '0, oneshot = '0, load = '0, irq_clr = '0;
    logic [63:0] top = '0;
    logic [63:0] cnt;
    logic [3:0]  running, irq_pend;
    logic        irq;
    int          checks = 0, errors = 0;

    multi_timer dut (
        .clk(clk), .rstn(rstn), .prescale(prescale), .en(en), .dir(dir),
        .oneshot(oneshot), .top(top), .load(load), .irq_clr(irq_clr),
        .cnt(cnt), .running(running), .irq_pend(irq_pend), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  pre;
        logic        en, dir, os;
        logic [15:0] top;
        logic        ld, clr;
        int          n;
        logic [15:0] ecnt;
        logic        erun, epend;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int pre, int e, int d, int os, int tp, int ld, int clr,
                                int n, int ecnt, int erun, int epend);
        vec_t v;
        v.pre = 8'(pre); v.en = 1'(e); v.dir = 1'(d); v.os = 1'(os); v.top = 16'(tp);
        v.ld = 1'(ld); v.clr = 1'(clr); v.n = n; v.ecnt = 16'(ecnt);
        v.erun = 1'(erun); v.epend = 1'(epend);
        return v;
    endfunction

    task automatic chk(string nm, int idx, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0h want %0h", nm, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int rst_cnt[6] = '{0, 0, 1, 1, 1, 2};

    initial begin
        // up periodic, top=3
        tbl.push_back(mk(0,1,1,0,3, 1,0, 1, 0,1,0));
        tbl.push_back(mk(0,1,1,0,3, 0,0, 1, 1,1,0));
        tbl.push_back(mk(0,1,1,0,3, 0,0, 1, 2,1,0));
        tbl.push_back(mk(0,1,1,0,3, 0,0, 1, 3,1,0));
        tbl.push_back(mk(0,1,1,0,3, 0,0, 1, 0,1,1));
        tbl.push_back(mk(0,1,1,0,3, 0,0, 1, 1,1,1));
        tbl.push_back(mk(0,1,1,0,3, 0,1, 1, 2,1,0));
        tbl.push_back(mk(0,1,1,0,3, 0,0, 1, 3,1,0));
        tbl.push_back(mk(0,1,1,0,3, 0,0, 1, 0,1,1));
        // down one-shot, prescale=2, top=5; prescaler phase is 0 at the load edge
        tbl.push_back(mk(2,1,0,1,5, 1,1, 1, 5,1,0));
        tbl.push_back(mk(2,1,0,1,5, 0,0, 1, 5,1,0));
        tbl.push_back(mk(2,1,0,1,5, 0,0, 3, 4,1,0));
        tbl.push_back(mk(2,1,0,1,5, 0,0, 3, 3,1,0));
        tbl.push_back(mk(2,1,0,1,5, 0,0, 3, 2,1,0));
        tbl.push_back(mk(2,1,0,1,5, 0,0, 3, 1,1,0));
        tbl.push_back(mk(2,1,0,1,5, 0,0, 3, 0,1,0));
        tbl.push_back(mk(2,1,0,1,5, 0,0, 1, 5,0,1));
        tbl.push_back(mk(2,1,0,1,5, 0,0, 7, 5,0,1));
        // pause/resume with top=10, then lower top and top=0
        tbl.push_back(mk(0,1,1,0,10, 1,1, 1, 0,1,0));
        tbl.push_back(mk(0,1,1,0,10, 0,0, 1, 1,1,0));
        tbl.push_back(mk(0,1,1,0,10, 0,0, 1, 2,1,0));
        tbl.push_back(mk(0,1,1,0,10, 0,0, 1, 3,1,0));
        tbl.push_back(mk(0,1,1,0,10, 0,0, 1, 4,1,0));
        tbl.push_back(mk(0,0,1,0,10, 0,0, 5, 4,0,0));
        tbl.push_back(mk(0,1,1,0,10, 0,0, 1, 4,1,0));
        tbl.push_back(mk(0,1,1,0,10, 0,0, 1, 5,1,0));
        tbl.push_back(mk(0,1,1,0,10, 0,0, 1, 6,1,0));
        tbl.push_back(mk(0,1,1,0,2,  0,0, 1, 0,1,1));
        tbl.push_back(mk(0,1,1,0,0,  0,1, 3, 0,1,1));
        tbl.push_back(mk(0,0,1,0,0,  0,1, 1, 0,0,0));
        // priority: load with en=0, load on a terminal tick
        tbl.push_back(mk(0,1,1,0,10, 0,0, 1, 0,1,0));
        tbl.push_back(mk(0,1,1,0,10, 0,0, 1, 1,1,0));
        tbl.push_back(mk(0,1,1,0,10, 0,0, 1, 2,1,0));
        tbl.push_back(mk(0,0,0,0,10, 1,0, 1, 10,0,0));
        tbl.push_back(mk(0,1,1,0,2,  1,0, 1, 0,1,0));
        tbl.push_back(mk(0,1,1,0,2,  0,0, 1, 1,1,0));
        tbl.push_back(mk(0,1,1,0,2,  0,0, 1, 2,1,0));
        tbl.push_back(mk(0,1,1,0,2,  1,0, 1, 0,1,0));
        tbl.push_back(mk(0,1,1,0,2,  0,0, 1, 1,1,0));

        #1 rstn = 1'b0;
        #2;
        chk("rst_cnt", 0, cnt, 64'd0);
        chk("rst_run", 0, 64'(running), 64'd0);
        chk("rst_pend", 0, 64'(irq_pend), 64'd0);
        chk("rst_irq", 0, 64'(irq), 64'd0);
        step();
        step();
        rstn = 1'b1;

        foreach (tbl[r]) begin
            prescale = tbl[r].pre;
            en       = {3'b0, tbl[r].en};
            dir      = {3'b0, tbl[r].dir};
            oneshot  = {3'b0, tbl[r].os};
            top      = {48'b0, tbl[r].top};
            load     = {3'b0, tbl[r].ld};
            irq_clr  = {3'b0, tbl[r].clr};
            for (int k = 0; k < tbl[r].n; k++) begin
                step();
                chk("cnt", r, 64'(cnt[15:0]), 64'(tbl[r].ecnt));
                chk("run", r, 64'(running[0]), 64'(tbl[r].erun));
                chk("pend", r, 64'(irq_pend[0]), 64'(tbl[r].epend));
                chk("irq", r, 64'(irq), 64'(tbl[r].epend));
            end
        end

        // four channels concurrently: up 3, down 6, up 4, down 9
        prescale = 8'd0;
        en       = 4'hF;
        dir      = 4'b0101;
        oneshot  = 4'h0;
        top      = {16'd9, 16'd4, 16'd6, 16'd3};
        load     = 4'hF;
        irq_clr  = 4'hF;
        for (int m = 0; m <= 12; m++) begin
            step();
            if (m == 0) begin
                load    = 4'h0;
                irq_clr = 4'h0;
            end
            chk("mc_run", m, 64'(running), 64'hF);
            chk("mc_irq", m, 64'(irq), 64'(m >= 4));
            for (int ch = 0; ch < 4; ch++) begin
                int t, ph;
                t  = int'(top[ch*16 +: 16]);
                ph = m % (t + 1);
                chk("mc_cnt", ch*100 + m, 64'(cnt[ch*16 +: 16]), 64'(dir[ch] ? ph : t - ph));
                chk("mc_pend", ch*100 + m, 64'(irq_pend[ch]), 64'(m >= t + 1));
            end
        end

        // asynchronous reset between edges while flags are pending
        #2 rstn = 1'b0;
        #1;
        chk("ar_cnt", 0, cnt, 64'd0);
        chk("ar_run", 0, 64'(running), 64'd0);
        chk("ar_pend", 0, 64'(irq_pend), 64'd0);
        chk("ar_irq", 0, 64'(irq), 64'd0);
        en       = 4'b0001;
        dir      = 4'hF;
        top      = {48'b0, 16'd3};
        prescale = 8'd2;
        rstn     = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("ar_seq_cnt", k, cnt, 64'(rst_cnt[k]));
            chk("ar_seq_run", k, 64'(running), 64'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
